// File: rtl/pipeline_hazard_ctrl.sv
// Turns RAW-hazard suspend and control-flow redirects into PC / IF/ID / ID/EX enables and flushes,
// with stall-episode tracking, a stall-length watchdog and debug performance counters.
//   state | meaning
//   RUN   | pipeline advancing normally
//   STALL | PC and IF/ID held, bubble into ID/EX
//   FLUSH | redirect in progress, IF/ID loaded with NOP
module pipeline_hazard_ctrl #(
    parameter int MAX_STALL = 7,
    parameter int CNT_W     = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             suspend_i,
    input  logic             branch_taken_i,
    input  logic             jump_i,
    input  logic             clr_cnt_i,
    output logic             pc_stall_o,
    output logic             if_id_stall_o,
    output logic             if_id_flush_o,
    output logic             id_exe_flush_o,
    output logic [1:0]       state_o,
    output logic [2:0]       stall_len_o,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [CNT_W-1:0] stall_events_o,
    output logic [CNT_W-1:0] flush_events_o,
    output logic             wdog_err_o
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_STALL = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [2:0]       LEN_MAX = 3'd7;

    logic             stall;
    logic             ifIdFlush;
    logic [1:0]       state;
    logic [1:0]       stateNext;
    logic [2:0]       stallLen;
    logic [2:0]       stallLenNext;
    logic             enterStall;
    logic             wdogHit;
    logic             wdogErr;
    logic [CNT_W-1:0] stallCycles;
    logic [CNT_W-1:0] stallEvents;
    logic [CNT_W-1:0] flushEvents;

    // A taken branch kills the stalled ID instruction, so it overrides suspend.
    assign stall     = suspend_i & ~branch_taken_i;
    assign ifIdFlush = branch_taken_i | (jump_i & ~suspend_i);

    assign pc_stall_o     = stall;
    assign if_id_stall_o  = stall;
    assign if_id_flush_o  = ifIdFlush;
    assign id_exe_flush_o = suspend_i | branch_taken_i;

    always_comb begin
        stateNext = ST_RUN;
        case (state)
            ST_RUN, ST_STALL, ST_FLUSH: begin
                if (stall)
                    stateNext = ST_STALL;
                else if (ifIdFlush)
                    stateNext = ST_FLUSH;
                else
                    stateNext = ST_RUN;
            end
            default: stateNext = ST_RUN;
        endcase
    end

    assign enterStall = (stateNext == ST_STALL) && (state != ST_STALL);

    always_comb begin
        stallLenNext = 3'd0;
        if (stateNext == ST_STALL) begin
            if (state != ST_STALL)
                stallLenNext = 3'd1;
            else if (stallLen != LEN_MAX)
                stallLenNext = stallLen + 3'd1;
            else
                stallLenNext = stallLen;
        end
    end

    assign wdogHit = (int'(stallLenNext) == MAX_STALL);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= ST_RUN;
            stallLen <= 3'd0;
        end else begin
            state    <= stateNext;
            stallLen <= stallLenNext;
        end
    end

    // Clear wins over a same-cycle event: that event is dropped, not deferred.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stallCycles <= '0;
            stallEvents <= '0;
            flushEvents <= '0;
            wdogErr     <= 1'b0;
        end else if (clr_cnt_i) begin
            stallCycles <= '0;
            stallEvents <= '0;
            flushEvents <= '0;
            wdogErr     <= 1'b0;
        end else begin
            if (stall)
                stallCycles <= stallCycles + CNT_ONE;
            if (enterStall)
                stallEvents <= stallEvents + CNT_ONE;
            if (ifIdFlush)
                flushEvents <= flushEvents + CNT_ONE;
            if (wdogHit)
                wdogErr <= 1'b1;
        end
    end

    assign state_o        = state;
    assign stall_len_o    = stallLen;
    assign stall_cycles_o = stallCycles;
    assign stall_events_o = stallEvents;
    assign flush_events_o = flushEvents;
    assign wdog_err_o     = wdogErr;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a vector table for the stall/flush decode and FSM,
// then hand-written sequences for the watchdog, async reset and 4-bit counter wrap.
module tb_pipeline_hazard_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic suspend;
    logic branchTaken;
    logic jump;
    logic clrCnt;

    logic        pcStall, ifIdStall, ifIdFlush, idExeFlush, wdogErr;
    logic [1:0]  state;
    logic [2:0]  stallLen;
    logic [31:0] stallCycles, stallEvents, flushEvents;

    logic        pcStall4, ifIdStall4, ifIdFlush4, idExeFlush4, wdogErr4;
    logic [1:0]  state4;
    logic [2:0]  stallLen4;
    logic [3:0]  stallCycles4, stallEvents4, flushEvents4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MAX_STALL(7), .CNT_W(32)) dut (
        .clk_i(clk), .rst_i(rst), .suspend_i(suspend), .branch_taken_i(branchTaken),
        .jump_i(jump), .clr_cnt_i(clrCnt),
        .pc_stall_o(pcStall), .if_id_stall_o(ifIdStall), .if_id_flush_o(ifIdFlush),
        .id_exe_flush_o(idExeFlush), .state_o(state), .stall_len_o(stallLen),
        .stall_cycles_o(stallCycles), .stall_events_o(stallEvents),
        .flush_events_o(flushEvents), .wdog_err_o(wdogErr)
    );

    pipeline_hazard_ctrl #(.MAX_STALL(7), .CNT_W(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .suspend_i(suspend), .branch_taken_i(branchTaken),
        .jump_i(jump), .clr_cnt_i(clrCnt),
        .pc_stall_o(pcStall4), .if_id_stall_o(ifIdStall4), .if_id_flush_o(ifIdFlush4),
        .id_exe_flush_o(idExeFlush4), .state_o(state4), .stall_len_o(stallLen4),
        .stall_cycles_o(stallCycles4), .stall_events_o(stallEvents4),
        .flush_events_o(flushEvents4), .wdog_err_o(wdogErr4)
    );

    typedef struct {
        logic       sus;
        logic       br;
        logic       jmp;
        logic       expPc;
        logic       expIfFl;
        logic       expIdFl;
        logic [1:0] expState;
        logic [2:0] expLen;
        int         expCyc;
        int         expEvt;
        int         expFl;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chkRegs(input string tag, input logic [1:0] st, input logic [2:0] len,
                           input int cy, input int ev, input int fl, input logic wd);
        chk({tag, " state"}, 64'(state), 64'(st));
        chk({tag, " stall_len"}, 64'(stallLen), 64'(len));
        chk({tag, " stall_cycles"}, 64'(stallCycles), 64'(cy));
        chk({tag, " stall_events"}, 64'(stallEvents), 64'(ev));
        chk({tag, " flush_events"}, 64'(flushEvents), 64'(fl));
        chk({tag, " wdog_err"}, 64'(wdogErr), 64'(wd));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation ran past its time limit");
        $fatal(1, "timeout");
    end

    initial begin
        //          sus br jmp  pc ifF idF  st    len  cyc evt fl
        vecs[0]  = '{0, 0, 0,   0, 0,  0,   2'd0, 3'd0, 0, 0, 0};
        vecs[1]  = '{1, 0, 0,   1, 0,  1,   2'd1, 3'd1, 1, 1, 0};
        vecs[2]  = '{1, 0, 0,   1, 0,  1,   2'd1, 3'd2, 2, 1, 0};
        vecs[3]  = '{1, 0, 0,   1, 0,  1,   2'd1, 3'd3, 3, 1, 0};
        vecs[4]  = '{0, 0, 0,   0, 0,  0,   2'd0, 3'd0, 3, 1, 0};
        vecs[5]  = '{1, 1, 0,   0, 1,  1,   2'd2, 3'd0, 3, 1, 1};
        vecs[6]  = '{0, 0, 0,   0, 0,  0,   2'd0, 3'd0, 3, 1, 1};
        vecs[7]  = '{1, 0, 1,   1, 0,  1,   2'd1, 3'd1, 4, 2, 1};
        vecs[8]  = '{1, 0, 1,   1, 0,  1,   2'd1, 3'd2, 5, 2, 1};
        vecs[9]  = '{0, 0, 1,   0, 1,  0,   2'd2, 3'd0, 5, 2, 2};
        vecs[10] = '{0, 0, 1,   0, 1,  0,   2'd2, 3'd0, 5, 2, 3};
        vecs[11] = '{0, 0, 0,   0, 0,  0,   2'd0, 3'd0, 5, 2, 3};
        vecs[12] = '{0, 1, 0,   0, 1,  1,   2'd2, 3'd0, 5, 2, 4};
        vecs[13] = '{1, 0, 0,   1, 0,  1,   2'd1, 3'd1, 6, 3, 4};
        vecs[14] = '{1, 1, 0,   0, 1,  1,   2'd2, 3'd0, 6, 3, 5};
        vecs[15] = '{0, 0, 0,   0, 0,  0,   2'd0, 3'd0, 6, 3, 5};

        rst = 1'b1; suspend = 1'b0; branchTaken = 1'b0; jump = 1'b0; clrCnt = 1'b0;
        repeat (2) cyc();
        chkRegs("reset", 2'd0, 3'd0, 0, 0, 0, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            suspend = vecs[i].sus; branchTaken = vecs[i].br; jump = vecs[i].jmp;
            #1;
            chk($sformatf("v%0d pc_stall", i), 64'(pcStall), 64'(vecs[i].expPc));
            chk($sformatf("v%0d if_id_stall", i), 64'(ifIdStall), 64'(vecs[i].expPc));
            chk($sformatf("v%0d if_id_flush", i), 64'(ifIdFlush), 64'(vecs[i].expIfFl));
            chk($sformatf("v%0d id_exe_flush", i), 64'(idExeFlush), 64'(vecs[i].expIdFl));
            cyc();
            chkRegs($sformatf("v%0d", i), vecs[i].expState, vecs[i].expLen,
                    vecs[i].expCyc, vecs[i].expEvt, vecs[i].expFl, 1'b0);
        end

        // Watchdog: 8-cycle stall, sticky error, clear.
        suspend = 1'b0; branchTaken = 1'b0; jump = 1'b0;
        clrCnt = 1'b1;
        cyc();
        clrCnt = 1'b0;
        chkRegs("clr1", 2'd0, 3'd0, 0, 0, 0, 1'b0);
        suspend = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            chk($sformatf("wd%0d stall_len", k), 64'(stallLen), (k < 7) ? 64'(k) : 64'd7);
            chk($sformatf("wd%0d wdog_err", k), 64'(wdogErr), (k >= 7) ? 64'd1 : 64'd0);
        end
        suspend = 1'b0;
        cyc();
        chkRegs("wd_end", 2'd0, 3'd0, 8, 1, 0, 1'b1);
        clrCnt = 1'b1;
        cyc();
        clrCnt = 1'b0;
        chkRegs("clr2", 2'd0, 3'd0, 0, 0, 0, 1'b0);

        // Two hazards separated by an idle cycle, then async reset mid-stall.
        suspend = 1'b1; cyc();
        suspend = 1'b0; cyc();
        suspend = 1'b1; cyc();
        chk("hz2 stall_events", 64'(stallEvents), 64'd2);
        cyc();
        chkRegs("hz2", 2'd1, 3'd2, 3, 2, 0, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        chkRegs("async_rst", 2'd0, 3'd0, 0, 0, 0, 1'b0);
        chk("async_rst pc_stall", 64'(pcStall), 64'd1);
        chk("async_rst id_exe_flush", 64'(idExeFlush), 64'd1);
        suspend = 1'b0;
        cyc();
        rst = 1'b0;
        chk("post_rst state", 64'(state), 64'd0);

        // Counter wrap on the 4-bit instance.
        branchTaken = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            cyc();
            if (k == 16)
                chk("wrap16 flush_events4", 64'(flushEvents4), 64'd0);
        end
        branchTaken = 1'b0;
        chk("wrap17 flush_events4", 64'(flushEvents4), 64'd1);
        chk("wrap17 flush_events32", 64'(flushEvents), 64'd17);
        chk("wrap17 state", 64'(state), 64'd2);
        cyc();
        chk("wrap_end state", 64'(state), 64'd0);
        chk("wrap_end stall_cycles4", 64'(stallCycles4), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
